// File: rtl/hadamard_pkg.sv
// Shared constants and state encoding for the 4-point Hadamard input framer and output collector.
package hadamard_pkg;

    localparam int unsigned HAD_DATA_W = 9;
    localparam int unsigned VEC_LEN    = 4;
    localparam int unsigned SLOT_W     = 2;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2
    } frame_state_e;

endpackage

// File: rtl/hold_timer.sv
// Down-counter holding a vector for a fixed number of cycles; loads on demand, stops at zero.
module hold_timer
    import hadamard_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/hadamard4pt_input_framer.sv
// Collects serial samples into 4-point vectors and holds each on x0..x3 for at least HOLD_CYCLES cycles.
module hadamard4pt_input_framer
    import hadamard_pkg::*;
#(
    parameter int unsigned DATA_W      = HAD_DATA_W,
    parameter int unsigned HOLD_CYCLES = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     s_ready,
    output logic signed [DATA_W-1:0] x0,
    output logic signed [DATA_W-1:0] x1,
    output logic signed [DATA_W-1:0] x2,
    output logic signed [DATA_W-1:0] x3,
    output logic                     start,
    output logic                     busy
);

    frame_state_e                        state_q, state_d;
    logic [VEC_LEN-1:0][DATA_W-1:0]      slot_q, slot_d;
    logic [VEC_LEN-1:0][DATA_W-1:0]      vec_q, vec_d;
    logic [SLOT_W-1:0]                   idx_q, idx_d;
    logic                                full_q, full_d;
    logic                                start_q;
    logic                                transfer_c;
    logic                                accept_c;
    logic                                tmr_zero;

    hold_timer #(.W(CNT_W)) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (transfer_c),
        .value (CNT_W'(HOLD_CYCLES - 1)),
        .zero  (tmr_zero)
    );

    // Next state and transfer decision; depends only on registered state, never on s_valid.
    always_comb begin
        state_d    = state_q;
        transfer_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (full_q) begin
                    transfer_c = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    if (full_q) begin
                        transfer_c = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign s_ready  = !rst && (!full_q || transfer_c);
    assign accept_c = s_valid && s_ready;

    // Collector: a transfer empties it first, so a same-cycle accept lands in slot 0.
    always_comb begin
        slot_d = slot_q;
        idx_d  = idx_q;
        full_d = full_q;
        vec_d  = vec_q;
        if (transfer_c) begin
            vec_d  = slot_q;
            full_d = 1'b0;
            idx_d  = '0;
        end
        if (accept_c) begin
            slot_d[idx_d] = s_data;
            full_d        = (idx_d == SLOT_W'(VEC_LEN - 1));
            idx_d         = idx_d + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            vec_q   <= '0;
            idx_q   <= '0;
            full_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            full_q  <= full_d;
            start_q <= transfer_c;
        end
    end

    assign x0    = vec_q[0];
    assign x1    = vec_q[1];
    assign x2    = vec_q[2];
    assign x3    = vec_q[3];
    assign start = start_q;
    assign busy  = (state_q == ST_HOLD);

endmodule

// File: tb/tb_hadamard4pt_input_framer.sv
// Randomized and directed checks of the 4-point input framer against a queue-based reference model.
module tb_hadamard4pt_input_framer;

    localparam int DW = 9;
    localparam int H  = 10;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 s_valid = 1'b0;
    logic signed [DW-1:0] s_data = '0;
    logic                 s_ready;
    logic signed [DW-1:0] x0, x1, x2, x3;
    logic                 start, busy;

    always #5 clk = ~clk;

    hadamard4pt_input_framer #(.DATA_W(DW), .HOLD_CYCLES(H)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .x0      (x0),
        .x1      (x1),
        .x2      (x2),
        .x3      (x3),
        .start   (start),
        .busy    (busy)
    );

    // Reference model: pending samples as a queue, hold expressed as busy cycles still to run.
    logic signed [DW-1:0] mq[$];
    logic signed [DW-1:0] mx[4];
    int                   hold_left = 0;
    logic                 mstart = 1'b0;
    logic                 mready = 1'b0;
    logic                 macc = 1'b0;
    logic                 rdy_obs = 1'b0;
    int                   checks = 0;
    int                   errors = 0;

    task automatic step(input logic r, input logic v, input logic signed [DW-1:0] d);
        bit full, xfer;
        @(negedge clk);
        rst = r; s_valid = v; s_data = d;
        #1;
        rdy_obs = s_ready;
        full    = (mq.size() == 4);
        xfer    = !r && full && (hold_left <= 1);
        mready  = !r && (!full || xfer);
        macc    = !r && v && mready;
        @(posedge clk);
        if (r) begin
            mq.delete();
            hold_left = 0;
            for (int i = 0; i < 4; i++) mx[i] = '0;
            mstart = 1'b0;
        end else begin
            mstart = xfer;
            if (xfer) begin
                for (int i = 0; i < 4; i++) mx[i] = mq[i];
                mq.delete();
                hold_left = H;
            end else if (hold_left > 0) begin
                hold_left--;
            end
            if (macc) mq.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b1, DW'($urandom));
            checks++; if (rdy_obs !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", rdy_obs); end
            checks++; if ({x0, x1, x2, x3} !== '0) begin errors++; $display("FAIL reset_x got %h want 0", {x0, x1, x2, x3}); end
            checks++; if (start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags got start=%b busy=%b want 0 0", start, busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic signed [DW-1:0] samp[8];
        logic [4*DW-1:0]      loads[$];
        int                   lc[$];
        int                   idx, nbusy;
        logic                 r, v;
        samp = '{DW'(3), DW'(4), DW'(-2), DW'(1), DW'(-1), DW'(6), DW'(2), DW'(4)};
        idx = 0; nbusy = 0;
        for (int c = 0; c < 40; c++) begin
            r = (c == 0);
            v = !r && idx < 8;
            step(r, v, v ? samp[idx] : '0);
            if (macc) idx++;
            checks++; if (rdy_obs !== mready) begin errors++; $display("FAIL b2b_ready c=%0d got %b want %b", c, rdy_obs, mready); end
            checks++; if (start !== mstart) begin errors++; $display("FAIL b2b_start c=%0d got %b want %b", c, start, mstart); end
            checks++; if (busy !== (hold_left > 0)) begin errors++; $display("FAIL b2b_busy c=%0d got %b want %b", c, busy, hold_left > 0); end
            checks++; if ({x0, x1, x2, x3} !== {mx[0], mx[1], mx[2], mx[3]}) begin errors++; $display("FAIL b2b_x c=%0d got %h want %h", c, {x0, x1, x2, x3}, {mx[0], mx[1], mx[2], mx[3]}); end
            if (c == 9) begin
                checks++; if (rdy_obs !== 1'b0) begin errors++; $display("FAIL b2b_full_blocks got %b want 0", rdy_obs); end
            end
            if (start === 1'b1) begin loads.push_back({x0, x1, x2, x3}); lc.push_back(c); end
            if (busy === 1'b1 && lc.size() == 1) nbusy++;
        end
        checks++;
        if (loads.size() != 2) begin
            errors++; $display("FAIL b2b_loads got %0d want 2", loads.size());
        end else begin
            checks++; if (lc[0] != 5) begin errors++; $display("FAIL b2b_latency got %0d want 5", lc[0]); end
            checks++; if (lc[1] - lc[0] != H) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", lc[1] - lc[0], H); end
            checks++; if (loads[0] !== {DW'(3), DW'(4), DW'(-2), DW'(1)}) begin errors++; $display("FAIL b2b_vec0 got %h", loads[0]); end
            checks++; if (loads[1] !== {DW'(-1), DW'(6), DW'(2), DW'(4)}) begin errors++; $display("FAIL b2b_vec1 got %h", loads[1]); end
            checks++; if (nbusy != H) begin errors++; $display("FAIL b2b_busy_len got %0d want %0d", nbusy, H); end
        end
    endtask

    task automatic test_toggle();
        logic signed [DW-1:0] samp[4];
        logic [4*DW-1:0]      loads[$];
        int                   idx;
        logic                 r, v;
        samp = '{DW'(5), DW'(-3), DW'(1), DW'(0)};
        idx = 0;
        for (int c = 0; c < 25; c++) begin
            r = (c == 0);
            v = !r && idx < 4 && (c % 2 == 1);
            step(r, v, v ? samp[idx] : DW'($urandom));
            if (macc) idx++;
            checks++; if (rdy_obs !== mready) begin errors++; $display("FAIL tog_ready c=%0d got %b want %b", c, rdy_obs, mready); end
            checks++; if (start !== mstart) begin errors++; $display("FAIL tog_start c=%0d got %b want %b", c, start, mstart); end
            checks++; if ({x0, x1, x2, x3} !== {mx[0], mx[1], mx[2], mx[3]}) begin errors++; $display("FAIL tog_x c=%0d got %h want %h", c, {x0, x1, x2, x3}, {mx[0], mx[1], mx[2], mx[3]}); end
            if (start === 1'b1) loads.push_back({x0, x1, x2, x3});
        end
        checks++;
        if (loads.size() != 1) begin
            errors++; $display("FAIL tog_loads got %0d want 1", loads.size());
        end else begin
            checks++; if (loads[0] !== {DW'(5), DW'(-3), DW'(1), DW'(0)}) begin errors++; $display("FAIL tog_vec got %h", loads[0]); end
        end
    endtask

    task automatic test_reset_midfill();
        logic signed [DW-1:0] samp[6];
        logic [4*DW-1:0]      loads[$];
        int                   idx, post_acc, acc4_c, first_start_c;
        logic                 r, v, did_rst;
        samp = '{DW'(-2), DW'(-3), DW'(-2), DW'(-3), DW'(-1), DW'(-5)};
        idx = 0; post_acc = 0; acc4_c = -1; first_start_c = -1; did_rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            r = (c == 0) || (idx == 2 && !did_rst);
            if (idx == 2 && r) did_rst = 1'b1;
            v = !r && idx < 6;
            step(r, v, v ? samp[idx] : '0);
            if (macc) begin
                idx++;
                if (did_rst) begin
                    post_acc++;
                    if (post_acc == 4) acc4_c = c;
                end
            end
            checks++; if (rdy_obs !== mready) begin errors++; $display("FAIL rmf_ready c=%0d got %b want %b", c, rdy_obs, mready); end
            checks++; if (start !== mstart) begin errors++; $display("FAIL rmf_start c=%0d got %b want %b", c, start, mstart); end
            checks++; if ({x0, x1, x2, x3} !== {mx[0], mx[1], mx[2], mx[3]}) begin errors++; $display("FAIL rmf_x c=%0d got %h want %h", c, {x0, x1, x2, x3}, {mx[0], mx[1], mx[2], mx[3]}); end
            if (start === 1'b1) begin
                loads.push_back({x0, x1, x2, x3});
                if (first_start_c < 0) first_start_c = c;
            end
        end
        checks++;
        if (loads.size() != 1) begin
            errors++; $display("FAIL rmf_loads got %0d want 1", loads.size());
        end else begin
            checks++; if (loads[0] !== {DW'(-2), DW'(-3), DW'(-1), DW'(-5)}) begin errors++; $display("FAIL rmf_vec got %h", loads[0]); end
            checks++; if (first_start_c != acc4_c + 1) begin errors++; $display("FAIL rmf_start_cycle got %0d want %0d", first_start_c, acc4_c + 1); end
        end
    endtask

    task automatic test_boundary();
        logic signed [DW-1:0] samp[4];
        logic [4*DW-1:0]      loads[$];
        int                   idx;
        logic                 r, v, prev_start;
        samp = '{DW'(-256), DW'(255), DW'(0), DW'(-1)};
        idx = 0; prev_start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            r = (c == 0);
            v = !r && idx < 4;
            step(r, v, v ? samp[idx] : '0);
            if (macc) idx++;
            checks++; if (start !== mstart) begin errors++; $display("FAIL bnd_start c=%0d got %b want %b", c, start, mstart); end
            checks++; if (prev_start && start === 1'b1) begin errors++; $display("FAIL bnd_start_twice c=%0d got 1 want 0", c); end
            if (start === 1'b1) loads.push_back({x0, x1, x2, x3});
            prev_start = start;
        end
        checks++;
        if (loads.size() != 1) begin
            errors++; $display("FAIL bnd_loads got %0d want 1", loads.size());
        end else begin
            checks++; if (loads[0] !== {9'h100, 9'h0FF, 9'h000, 9'h1FF}) begin errors++; $display("FAIL bnd_vec got %h want %h", loads[0], {9'h100, 9'h0FF, 9'h000, 9'h1FF}); end
        end
    endtask

    task automatic test_hold_expiry();
        logic signed [DW-1:0] samp[12];
        logic [4*DW-1:0]      loads[$];
        logic [4*DW-1:0]      exp_vec[3];
        int                   idx;
        logic                 r, v;
        for (int i = 0; i < 12; i++) samp[i] = DW'($urandom);
        for (int g = 0; g < 3; g++) exp_vec[g] = {samp[4*g], samp[4*g+1], samp[4*g+2], samp[4*g+3]};
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            r = (c == 0);
            v = !r && idx < 12;
            step(r, v, v ? samp[idx] : '0);
            if (macc) idx++;
            checks++; if (rdy_obs !== mready) begin errors++; $display("FAIL hex_ready c=%0d got %b want %b", c, rdy_obs, mready); end
            checks++; if (busy !== (hold_left > 0)) begin errors++; $display("FAIL hex_busy c=%0d got %b want %b", c, busy, hold_left > 0); end
            if (start === 1'b1) begin
                loads.push_back({x0, x1, x2, x3});
                if (loads.size() == 2) begin
                    checks++; if (rdy_obs !== 1'b1) begin errors++; $display("FAIL hex_same_edge_accept got %b want 1", rdy_obs); end
                end
            end
        end
        checks++;
        if (loads.size() != 3) begin
            errors++; $display("FAIL hex_loads got %0d want 3", loads.size());
        end else begin
            for (int g = 0; g < 3; g++) begin
                checks++; if (loads[g] !== exp_vec[g]) begin errors++; $display("FAIL hex_vec%0d got %h want %h", g, loads[g], exp_vec[g]); end
            end
        end
    endtask

    task automatic test_random();
        logic r, v;
        for (int c = 0; c < 600; c++) begin
            r = (c == 0) || ($urandom_range(0, 149) == 0);
            v = $urandom_range(0, 9) < 6;
            step(r, v, DW'($urandom));
            checks++; if (rdy_obs !== mready) begin errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c, rdy_obs, mready); end
            checks++; if (start !== mstart) begin errors++; $display("FAIL rnd_start c=%0d got %b want %b", c, start, mstart); end
            checks++; if (busy !== (hold_left > 0)) begin errors++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, hold_left > 0); end
            checks++; if ({x0, x1, x2, x3} !== {mx[0], mx[1], mx[2], mx[3]}) begin errors++; $display("FAIL rnd_x c=%0d got %h want %h", c, {x0, x1, x2, x3}, {mx[0], mx[1], mx[2], mx[3]}); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_toggle();
        test_reset_midfill();
        test_boundary();
        test_hold_expiry();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hadamard4pt_input_framer.md
HADAMARD4PT_INPUT_FRAMER -- requirements
Module: hadamard4pt_input_framer

Interface
REQ-001 Parameter DATA_W, default 9: signed sample width, matching Hadamard4ptsystolic2d x/y ports.
REQ-002 Parameter HOLD_CYCLES, default 10: minimum clk cycles each vector is held on x0..x3 (range 2..255).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s_valid  input  1  upstream sample valid.
REQ-006 s_data  input  DATA_W signed  serial sample; first sample of each group maps to x0, last to x3.
REQ-007 s_ready  output  1  framer can accept s_data this cycle.
REQ-008 x0, x1, x2, x3  output  DATA_W signed each  held vector to Hadamard4ptsystolic2d.
REQ-009 start  output  1  one-cycle pulse marking a new vector on x0..x3.
REQ-010 busy  output  1  high while a vector is inside its hold window.

Function
REQ-011 A sample SHALL be accepted only on an edge where s_valid and s_ready are both high.
REQ-012 Accepted samples SHALL fill collector slots 0..3 in order; the 2-bit slot index SHALL wrap from 3 to 0 on transfer.
REQ-013 s_ready SHALL be high when the collector holds fewer than 4 samples, or when a transfer occurs in the same cycle; otherwise low.
REQ-014 The FSM SHALL have states IDLE (no vector issued since reset), HOLD (counter running) and WAIT (hold expired, no vector pending).
REQ-015 Transfer SHALL occur when the collector is full and the state is IDLE or WAIT: x0..x3 load from slots 0..3 on that edge, start is 1 for the following cycle only, state goes to HOLD, counter loads HOLD_CYCLES-1.
REQ-016 In HOLD the counter SHALL decrement each cycle; at 0 the state SHALL go to WAIT, or transfer directly (stay in HOLD, reload counter) if the collector is full.
REQ-017 Minimum latency: 4th sample accepted at edge k with state IDLE/WAIT gives the collector full after edge k, and x0..x3 update plus start high on edge k+1.
REQ-018 Vector loads SHALL be spaced at least HOLD_CYCLES cycles apart; x0..x3 SHALL stay stable between loads.
REQ-019 Transfer and acceptance in the same cycle: the new sample SHALL go to slot 0 of the emptied collector.
REQ-020 busy SHALL equal (state == HOLD).
REQ-021 Sample values SHALL pass unmodified (no saturation or extension); full range -2^(DATA_W-1)..2^(DATA_W-1)-1.

Reset
REQ-022 While rst is high, at each edge: x0..x3=0, start=0, busy=0, slot index=0, counter=0, state=IDLE, collector cleared.
REQ-023 s_ready SHALL be 0 in any cycle where rst is high.
REQ-024 Reset mid-fill or mid-hold SHALL discard partial groups and the held vector; the first group after reset starts at slot 0.

Structure
REQ-025 DATA_W, the 4-point vector length constant and the FSM state encoding SHALL live in the shared package hadamard_pkg for reuse by the output collector.
REQ-026 The hold counter SHALL be a sub-module hold_timer (load, value, zero flag).
REQ-027 The design SHALL have no combinational path from s_valid to s_ready.

Verification
REQ-028 After reset, stream 3,4,-2,1 back-to-back -> x0..x3=3,4,-2,1 one edge after the 4th accept, start high exactly 1 cycle, busy high 10 cycles.
REQ-029 Stream 8 samples (3,4,-2,1,-1,6,2,4) with s_valid held high -> s_ready low once the second group fills; -1,6,2,4 loads exactly 10 cycles after the first load.
REQ-030 Toggle s_valid every other cycle with group 5,-3,1,0 -> vector loads correctly; no sample lost or duplicated.
REQ-031 rst pulsed after 2 of 4 samples (-2,-3), then -2,-3,-1,-5 sent -> output is -2,-3,-1,-5; no start before the 4th post-reset accept.
REQ-032 Boundary values -256,255,0,-1 -> output identical bit patterns; start never high two cycles in a row.
REQ-033 Collector full when hold expires while a sample is offered -> transfer and slot-0 acceptance on the same edge; next group completes correctly.
